// File: rtl/nmea_pkg.sv
// nmea_pkg: sequencer states, NMEA framing characters and hex-digit decode
package nmea_pkg;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_CK1, S_CK2, S_EOL} state_t;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;

    // {valid, nibble}; uppercase A-F only
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
               (c >= 8'h41 && c <= 8'h46) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
    endfunction

endpackage

// File: rtl/rx_strobe_sync.sv
// rx_strobe_sync: falling-edge strobe on uart_rx busy flag, holding the byte seen while it was high
module rx_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_int,
    input  logic [7:0] rx_data,
    output logic       rx_stb,
    output logic [7:0] rx_byte
);

    logic q0, q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q0      <= 1'b0;
            q1      <= 1'b0;
            rx_byte <= '0;
        end else begin
            q0      <= rx_int;
            q1      <= q0;
            rx_byte <= rx_int ? rx_data : rx_byte;
        end
    end

    assign rx_stb = q1 & ~q0;

endmodule

// File: rtl/nmea_frame_ctrl.sv
// nmea_frame_ctrl: NMEA sentence framing sequencer feeding field capture.
// Define NMEA_CKSUM_EN to compare the '*hh' checksum against the running XOR.
module nmea_frame_ctrl
    import nmea_pkg::*;
#(
    parameter logic [39:0] HDR     = 40'h4750524D43,
    parameter logic [7:0]  MAX_LEN = 8'd82,
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_int,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic [4:0] fld_idx,
    output logic [3:0] chr_idx,
    output logic       in_sentence,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_err
);

    logic        rx_stb;
    logic [7:0]  rx_byte;
    state_t      state;
    logic [2:0]  hdr_cnt;
    logic [39:0] hdr_sr;
    logic [7:0]  len;
    logic [23:0] timer;
    logic [4:0]  hex;
    logic        hex_ok, is_dollar, bad_byte, abort, ck_match;
`ifdef NMEA_CKSUM_EN
    logic [7:0]  xor_acc, cksum;
`endif

    rx_strobe_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_int  (rx_int),
        .rx_data (rx_data),
        .rx_stb  (rx_stb),
        .rx_byte (rx_byte)
    );

    // len never exceeds MAX_LEN while active, so len==MAX_LEN flags the overlong byte
    always_comb begin
        hex       = hex2nib(rx_byte);
        hex_ok    = hex >= 5'h10;
        is_dollar = rx_byte == CH_DOLLAR;
        bad_byte  = (state == S_HDR && rx_byte != hdr_sr[39:32]) ||
                    ((state == S_CK1 || state == S_CK2) && !hex_ok) ||
                    (state == S_EOL && rx_byte != CH_CR) ||
                    len == MAX_LEN;
        abort     = state != S_IDLE && (rx_stb ? !is_dollar && bad_byte : timer == TIMEOUT);
`ifdef NMEA_CKSUM_EN
        ck_match  = cksum == xor_acc;
`else
        ck_match  = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            hdr_cnt     <= '0;
            hdr_sr      <= '0;
            len         <= '0;
            timer       <= '0;
            byte_vld    <= 1'b0;
            byte_data   <= '0;
            fld_idx     <= '0;
            chr_idx     <= '0;
            in_sentence <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_vld   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            timer      <= (state == S_IDLE || rx_stb) ? '0 : timer + 24'd1;
            if (rx_stb && is_dollar) begin
                frame_done  <= in_sentence;
                frame_err   <= in_sentence;
                in_sentence <= 1'b0;
                state       <= S_HDR;
                hdr_cnt     <= '0;
                hdr_sr      <= HDR;
                len         <= 8'd1;
            end else if (abort) begin
                frame_done  <= in_sentence;
                frame_err   <= in_sentence;
                in_sentence <= 1'b0;
                state       <= S_IDLE;
            end else if (rx_stb && state != S_IDLE) begin
                len <= len + 8'd1;
                case (state)
                    S_HDR: begin
                        hdr_sr  <= hdr_sr << 8;
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == 3'd4) begin
                            state       <= S_BODY;
                            in_sentence <= 1'b1;
                            fld_idx     <= '0;
                            chr_idx     <= '0;
                        end
                    end
                    S_BODY: begin
                        if (rx_byte == CH_STAR) begin
                            state <= S_CK1;
                        end else begin
                            byte_vld  <= 1'b1;
                            byte_data <= rx_byte;
                            fld_idx   <= (rx_byte == CH_COMMA) ? fld_idx + {4'd0, fld_idx != 5'd31} : fld_idx;
                            chr_idx   <= (rx_byte == CH_COMMA) ? 4'd0 : chr_idx + {3'd0, chr_idx != 4'd15};
                        end
                    end
                    S_CK1: state <= S_CK2;
                    S_CK2: state <= S_EOL;
                    S_EOL: begin
                        frame_done  <= 1'b1;
                        frame_ok    <= ck_match;
                        frame_err   <= !ck_match;
                        in_sentence <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef NMEA_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || (rx_stb && is_dollar)) begin
            xor_acc <= '0;
            cksum   <= '0;
        end else if (rx_stb && !abort) begin
            if (state == S_HDR || (state == S_BODY && rx_byte != CH_STAR))
                xor_acc <= xor_acc ^ rx_byte;
            if (state == S_CK1 || state == S_CK2)
                cksum <= {cksum[3:0], hex[3:0]};
        end
    end
`endif

endmodule

// File: tb/tb_nmea_frame_ctrl.sv
// tb_nmea_frame_ctrl: directed and random sentences checked every cycle against a sentence-level model
`timescale 1ns/1ps
module tb_nmea_frame_ctrl;

    localparam logic [39:0] HDR     = 40'h4750524D43;
    localparam int          MAX_LEN = 82;
    localparam int          TMO     = 300;

    logic       clk = 1'b0, rst = 1'b1, rx_int = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       byte_vld, in_sentence, frame_done, frame_ok, frame_err;
    logic [7:0] byte_data;
    logic [4:0] fld_idx;
    logic [3:0] chr_idx;

    int checks = 0, errors = 0;
    bit run = 0;

    nmea_frame_ctrl #(.HDR(HDR), .MAX_LEN(8'(MAX_LEN)), .TIMEOUT(24'(TMO))) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_int      (rx_int),
        .byte_vld    (byte_vld),
        .byte_data   (byte_data),
        .fld_idx     (fld_idx),
        .chr_idx     (chr_idx),
        .in_sentence (in_sentence),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: works on the text received since '$'
    bit         h0, h1, m_stb, active, e_vld, e_ins, e_done, e_ok, e_err;
    logic [7:0] d, m_b, e_data;
    int         e_fld, e_chr, sil;
    logic [7:0] q[$];

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    function automatic logic [3:0] hexval(input logic [7:0] c);
        return c <= 8'h39 ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    task automatic fail_frame();
        if (e_ins) begin
            e_done = 1; e_err = 1; e_ins = 0;
        end
        active = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n, star, lastc, commas;
        if (b == 8'h24) begin
            fail_frame();
            active = 1;
            q.delete();
            return;
        end
        if (!active) return;
        q.push_back(b);
        n = q.size();
        if (n + 1 > MAX_LEN) begin
            fail_frame();
            return;
        end
        if (n <= 5) begin
            if (b != HDR[8*(5-n) +: 8]) active = 0;
            else if (n == 5) e_ins = 1;
            return;
        end
        star = -1; lastc = 4; commas = 0;
        for (int i = 5; i < n; i++) begin
            if (star < 0 && q[i] == 8'h2A) star = i;
            else if (star < 0 && q[i] == 8'h2C) begin
                commas++;
                lastc = i;
            end
        end
        if (star < 0) begin
            e_vld  = 1;
            e_data = b;
            e_fld  = commas > 31 ? 31 : commas;
            e_chr  = (b == 8'h2C) ? 0 : ((n - 1 - lastc) > 15 ? 15 : n - 1 - lastc);
        end else if (star == n - 1) begin
            e_vld = 0;
        end else if (n - 1 - star <= 2) begin
            if (!is_hex(b)) fail_frame();
        end else if (b != 8'h0D) begin
            fail_frame();
        end else begin
`ifdef NMEA_CKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i < star; i++) x ^= q[i];
                e_ok = {hexval(q[star+1]), hexval(q[star+2])} == x;
            end
`else
            e_ok = 1;
`endif
            e_err = !e_ok; e_done = 1; e_ins = 0; active = 0;
        end
    endtask

    always @(posedge clk) begin
        e_vld = 0; e_done = 0; e_ok = 0; e_err = 0;
        if (rst) begin
            h0 = 0; h1 = 0; d = 8'h00; active = 0; e_ins = 0; sil = 0;
            q.delete();
        end else begin
            m_stb = h1 && !h0;
            m_b   = d;
            h1 = h0; h0 = rx_int;
            if (rx_int) d = rx_data;
            if (m_stb) begin
                sil = 0;
                model_byte(m_b);
            end else if (active) begin
                if (sil == TMO) begin
                    fail_frame();
                    sil = 0;
                end else sil++;
            end
        end
    end

    // ---------------- per-cycle compare plus DUT event tallies for directed checks
    int          n_vld = 0, n_ok = 0, n_err = 0, n_done = 0, n_ins = 0;
    int          vld0, ok0, err0, done0, ins0;
    logic [16:0] vq[$];

    always @(negedge clk) if (run) begin
        chk("byte_vld", byte_vld, e_vld);
        chk("in_sentence", in_sentence, e_ins);
        chk("frame_done", frame_done, e_done);
        chk("frame_ok", frame_ok, e_ok);
        chk("frame_err", frame_err, e_err);
        if (e_vld) begin
            chk("byte_data", byte_data, e_data);
            chk("fld_idx", fld_idx, e_fld);
            chk("chr_idx", chr_idx, e_chr);
        end
        if (byte_vld) begin
            n_vld++;
            vq.push_back({byte_data, fld_idx, chr_idx});
        end
        if (frame_done) n_done++;
        if (frame_done && frame_ok) n_ok++;
        if (frame_done && frame_err) n_err++;
        if (in_sentence) n_ins++;
    end

    // ---------------- stimulus
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_int  = 1'b1;
        idle($urandom_range(1, 3));
        rx_int  = 1'b0;
        idle($urandom_range(1, 3));
    endtask

    task automatic send_str(input string s, input bit cr);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        if (cr) send_byte(8'h0D);
        idle(4);
    endtask

    task automatic snap();
        vld0 = n_vld; ok0 = n_ok; err0 = n_err; done0 = n_done; ins0 = n_ins;
        vq.delete();
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    function automatic logic [7:0] rand_chr();
        int c;
        c = $urandom_range(0, 36);
        return c < 10 ? 8'(8'h30 + c) : c < 36 ? 8'(8'h37 + c) : 8'h2E;
    endfunction

    logic [7:0] msg[$];
    logic [7:0] x;
    int         kind, nf, nc, len_cut;

    initial begin
        idle(3);
        run = 1;
        @(negedge clk);
        chk("reset_outputs", {byte_vld, in_sentence, frame_done, frame_ok, frame_err, fld_idx, chr_idx}, 0);
        idle(1);
        rst = 1'b0;
        idle(3);

        snap();
        send_str("$GPRMC,1*56", 1);
        chk("t1_ok", n_ok - ok0, 1);
        chk("t1_err", n_err - err0, 0);
        chk("t1_nvld", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("t1_vld0", vq[0], {8'h2C, 5'd1, 4'd0});
            chk("t1_vld1", vq[1], {8'h31, 5'd1, 4'd1});
        end

        snap();
        send_str("$GPRMC,1*57", 1);
`ifdef NMEA_CKSUM_EN
        chk("t2_err", n_err - err0, 1);
        chk("t2_ok", n_ok - ok0, 0);
`else
        chk("t2_err", n_err - err0, 0);
        chk("t2_ok", n_ok - ok0, 1);
`endif

        snap();
        send_str("$GPGGA,1*56", 1);
        chk("t3_vld", n_vld - vld0, 0);
        chk("t3_done", n_done - done0, 0);
        chk("t3_ins", n_ins - ins0, 0);

        snap();
        send_str("$GPRMC,12$GPRMC,1*56", 1);
        chk("t4_err", n_err - err0, 1);
        chk("t4_ok", n_ok - ok0, 1);
        chk("t4_nvld", vq.size(), 5);
        if (vq.size() == 5) chk("t4_restart", vq[3], {8'h2C, 5'd1, 4'd0});

        snap();
        send_str("$GPRMC,1", 0);
        idle(TMO + 20);
        chk("t5_timeout_err", n_err - err0, 1);
        send_str("$GPRMC,1*56", 1);
        chk("t5_after_ok", n_ok - ok0, 1);

        snap();
        send_str("$GPRMC", 0);
        for (int i = 0; i < 90; i++) send_byte(i % 8 == 0 ? 8'h2C : 8'(8'h30 + i % 10));
        idle(4);
        chk("t6_long_err", n_err - err0, 1);
        chk("t6_long_nvld", n_vld - vld0, 76);
        chk("t6_long_ins", in_sentence, 0);

        snap();
        send_str("$GPRMC,123", 0);
        chk("rst_pre_ins", in_sentence, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", {byte_vld, in_sentence, frame_done, frame_ok, frame_err, fld_idx, chr_idx}, 0);
        idle(1);
        rst = 1'b0;
        idle(5);
        chk("rst_mid_nodone", n_done - done0, 0);

        for (int s = 0; s < 160; s++) begin
            kind = $urandom_range(0, 11);
            msg.delete();
            msg.push_back(8'h24);
            for (int i = 0; i < 5; i++) msg.push_back(HDR[8*(4-i) +: 8]);
            if (kind == 0) msg[$urandom_range(1, 5)] ^= 8'h01;
            nf = kind == 5 ? $urandom_range(20, 40) : $urandom_range(0, 6);
            for (int f = 0; f < nf; f++) begin
                msg.push_back(8'h2C);
                nc = kind == 6 ? 18 : kind == 5 ? $urandom_range(0, 3) : $urandom_range(0, 6);
                for (int c = 0; c < nc; c++) msg.push_back(rand_chr());
            end
            x = 8'h00;
            for (int i = 1; i < msg.size(); i++) x ^= msg[i];
            if (kind == 1) x = x + 8'h01;
            msg.push_back(8'h2A);
            msg.push_back(hexc(x[7:4]));
            msg.push_back(kind == 2 ? ($urandom_range(0, 1) ? 8'h61 : 8'h47) : hexc(x[3:0]));
            msg.push_back(kind == 3 ? 8'h58 : 8'h0D);
            if (kind == 4) msg.insert($urandom_range(2, msg.size() - 1), 8'h24);
            if (kind == 7) begin
                len_cut = $urandom_range(2, msg.size() - 1);
                while (msg.size() > len_cut) void'(msg.pop_back());
            end
            if (kind == 8) for (int i = 0; i < 3; i++) msg.push_front(rand_chr());
            foreach (msg[i]) send_byte(msg[i]);
            idle(kind == 7 ? TMO + 10 : $urandom_range(0, 4));
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
